// File: rtl/crypto_instr_pkg.sv
// Shared types for the crypto coprocessor issue/result interface.
// CRYPTO_XLEN stands in for riscv::XLEN in this slice.
package crypto_instr_pkg;

  localparam int unsigned CRYPTO_XLEN          = 32;
  localparam int unsigned CRYPTO_TRANS_ID_BITS = 3;

  typedef struct packed {
    logic       accept;
    logic       writeback;
    logic [2:0] register_read;
  } issue_resp_t;

  typedef struct packed {
    logic                            busy;
    logic                            killed;
    logic [4:0]                      rd;
    logic [CRYPTO_TRANS_ID_BITS-1:0] trans_id;
  } xif_entry_t;

  typedef struct packed {
    logic [CRYPTO_XLEN-1:0]          data;
    logic [CRYPTO_TRANS_ID_BITS-1:0] trans_id;
    logic [4:0]                      rd;
    logic                            we;
    logic                            ex;
  } xif_wb_t;

  typedef enum logic {IDLE, REQ} req_state_e;

  // There is no rs3 operand path, so a request that needs rs3 can never be allocated.
  function automatic logic resp_allocates(logic accept, logic writeback, logic rs3_read);
    return accept && writeback && !rs3_read;
  endfunction

endpackage

// File: rtl/crypto_xif_issuer_if.sv
// Coprocessor-side issue and result channels; master is the core-side issuer.
interface crypto_xif_issuer_if
  import crypto_instr_pkg::*;
#(
  parameter int unsigned XLEN   = CRYPTO_XLEN,
  parameter int unsigned NR_IDS = 4
);
  localparam int unsigned IDW = $clog2(NR_IDS);

  logic            issue_valid;
  logic            issue_ready;
  logic [31:0]     issue_instr;
  logic [IDW-1:0]  issue_id;
  logic [XLEN-1:0] issue_rs1;
  logic [XLEN-1:0] issue_rs2;
  issue_resp_t     issue_resp;
  logic            result_valid;
  logic            result_ready;
  logic [IDW-1:0]  result_id;
  logic [XLEN-1:0] result_data;

  modport master (
    output issue_valid, issue_instr, issue_id, issue_rs1, issue_rs2, result_ready,
    input  issue_ready, issue_resp, result_valid, result_id, result_data
  );

  modport slave (
    input  issue_valid, issue_instr, issue_id, issue_rs1, issue_rs2, result_ready,
    output issue_ready, issue_resp, result_valid, result_id, result_data
  );
endinterface

// File: rtl/crypto_xif_id_table.sv
// Outstanding-transaction table indexed by coprocessor id: allocate, free, lookup, flush-kill.
module crypto_xif_id_table
  import crypto_instr_pkg::*;
#(
  parameter int unsigned NR_IDS = 4,
  localparam int unsigned IDW   = $clog2(NR_IDS)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            alloc_i,
  input  logic [IDW-1:0]                  alloc_id_i,
  input  logic [4:0]                      alloc_rd_i,
  input  logic [CRYPTO_TRANS_ID_BITS-1:0] alloc_trans_id_i,
  input  logic                            free_i,
  input  logic [IDW-1:0]                  result_id_i,
  output xif_entry_t                      lookup_o,
  output logic                            full_o,
  output logic                            any_busy_o
);

  xif_entry_t tbl_q [NR_IDS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NR_IDS; i++) tbl_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NR_IDS; i++) begin
        if (flush_i && tbl_q[i].busy) tbl_q[i].killed <= 1'b1;
      end
      if (free_i) tbl_q[result_id_i] <= '0;
      // An issue that coincides with a flush is still allocated, but born killed.
      if (alloc_i) begin
        tbl_q[alloc_id_i].busy     <= 1'b1;
        tbl_q[alloc_id_i].killed   <= flush_i;
        tbl_q[alloc_id_i].rd       <= alloc_rd_i;
        tbl_q[alloc_id_i].trans_id <= alloc_trans_id_i;
      end
    end
  end

  assign lookup_o = tbl_q[result_id_i];
  assign full_o   = tbl_q[alloc_id_i].busy;

  always_comb begin
    any_busy_o = 1'b0;
    for (int unsigned i = 0; i < NR_IDS; i++) any_busy_o = any_busy_o | tbl_q[i].busy;
  end

endmodule

// File: rtl/crypto_xif_issuer.sv
// Core-side initiator for the crypto coprocessor issue/result interface.
// Optional issue-handshake timeout: define CRYPTO_XIF_ISSUE_TIMEOUT_EN.
module crypto_xif_issuer
  import crypto_instr_pkg::*;
#(
  parameter int unsigned XLEN          = CRYPTO_XLEN,
  parameter int unsigned NR_IDS        = 4,
  parameter int unsigned TRANS_ID_BITS = CRYPTO_TRANS_ID_BITS
`ifdef CRYPTO_XIF_ISSUE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  logic [31:0]              instr_i,
  input  logic [XLEN-1:0]          rs1_i,
  input  logic [XLEN-1:0]          rs2_i,
  input  logic [4:0]               rd_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  crypto_xif_issuer_if.master      xif,
  output logic                     wb_valid_o,
  output logic [XLEN-1:0]          wb_data_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [4:0]               wb_rd_o,
  output logic                     wb_we_o,
  output logic                     wb_ex_o,
  output logic                     busy_o,
  output logic                     id_err_o
);

  localparam int unsigned IDW = $clog2(NR_IDS);

  req_state_e               state_q, state_d;
  logic [31:0]              instr_q;
  logic [XLEN-1:0]          rs1_q, rs2_q;
  logic [4:0]               rd_q;
  logic [TRANS_ID_BITS-1:0] tid_q;
  logic [IDW-1:0]           alloc_ptr_q;
  logic                     pend_q, pend_ex_q, pend_set, pend_ex_d;
  xif_wb_t                  wb_q, wb_d;
  logic                     wb_valid_q, wb_valid_d;
  logic                     id_err_q;
  logic                     issue_valid, instr_hs, issue_hs, result_hs;
  logic                     alloc, free, table_full, any_busy, timeout;
  xif_entry_t               res_entry;
  logic                     unused_rr;

  always_comb begin
    state_d       = state_q;
    instr_ready_o = 1'b0;
    issue_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready_o = !table_full && !pend_q;
        if (instr_valid_i && instr_ready_o) state_d = REQ;
      end
      REQ: begin
        issue_valid = 1'b1;
        if (flush_i || xif.issue_ready || timeout) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  assign instr_hs  = instr_valid_i & instr_ready_o;
  assign issue_hs  = issue_valid & xif.issue_ready;
  assign result_hs = xif.result_valid & xif.result_ready;
  assign alloc     = issue_hs & resp_allocates(xif.issue_resp.accept, xif.issue_resp.writeback,
                                               xif.issue_resp.register_read[2]);
  assign free      = result_hs & res_entry.busy;
  assign pend_set  = !flush_i & ((issue_hs & !alloc) | timeout);
  assign pend_ex_d = timeout | !xif.issue_resp.accept | xif.issue_resp.register_read[2];
  assign unused_rr = ^xif.issue_resp.register_read[1:0];

  assign xif.issue_valid  = issue_valid;
  assign xif.issue_instr  = instr_q;
  assign xif.issue_id     = alloc_ptr_q;
  assign xif.issue_rs1    = rs1_q;
  assign xif.issue_rs2    = rs2_q;
  assign xif.result_ready = !pend_q;

`ifdef CRYPTO_XIF_ISSUE_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               tmo_q <= '0;
    else if (instr_hs)         tmo_q <= '0;
    else if (state_q == REQ)   tmo_q <= tmo_q + TMO_W'(1);
  end

  assign timeout = (state_q == REQ) && !xif.issue_ready && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // pend_q blocks result_ready, so a pending completion and a result never collide here.
  always_comb begin
    wb_valid_d = 1'b0;
    wb_d       = wb_q;
    if (!flush_i) begin
      if (pend_q) begin
        wb_valid_d    = 1'b1;
        wb_d.data     = '0;
        wb_d.trans_id = tid_q;
        wb_d.rd       = rd_q;
        wb_d.we       = 1'b0;
        wb_d.ex       = pend_ex_q;
      end else if (free && !res_entry.killed) begin
        wb_valid_d    = 1'b1;
        wb_d.data     = xif.result_data;
        wb_d.trans_id = res_entry.trans_id;
        wb_d.rd       = res_entry.rd;
        wb_d.we       = 1'b1;
        wb_d.ex       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      tid_q       <= '0;
      alloc_ptr_q <= '0;
      pend_q      <= 1'b0;
      pend_ex_q   <= 1'b0;
      wb_q        <= '0;
      wb_valid_q  <= 1'b0;
      id_err_q    <= 1'b0;
    end else begin
      if (instr_hs) begin
        instr_q <= instr_i;
        rs1_q   <= rs1_i;
        rs2_q   <= rs2_i;
        rd_q    <= rd_i;
        tid_q   <= trans_id_i;
      end
      if (alloc) alloc_ptr_q <= alloc_ptr_q + IDW'(1);
      if (flush_i) begin
        pend_q <= 1'b0;
      end else if (pend_set) begin
        pend_q    <= 1'b1;
        pend_ex_q <= pend_ex_d;
      end else if (pend_q) begin
        pend_q <= 1'b0;
      end
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
      if (result_hs && !res_entry.busy) id_err_q <= 1'b1;
    end
  end

  crypto_xif_id_table #(.NR_IDS(NR_IDS)) u_id_table (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .alloc_i          (alloc),
    .alloc_id_i       (alloc_ptr_q),
    .alloc_rd_i       (rd_q),
    .alloc_trans_id_i (tid_q),
    .free_i           (free),
    .result_id_i      (xif.result_id),
    .lookup_o         (res_entry),
    .full_o           (table_full),
    .any_busy_o       (any_busy)
  );

  assign wb_valid_o    = wb_valid_q;
  assign wb_data_o     = wb_q.data;
  assign wb_trans_id_o = wb_q.trans_id;
  assign wb_rd_o       = wb_q.rd;
  assign wb_we_o       = wb_q.we;
  assign wb_ex_o       = wb_q.ex;
  assign busy_o        = (state_q == REQ) | pend_q | any_busy;
  assign id_err_o      = id_err_q;

endmodule

// File: tb/tb_crypto_xif_issuer.sv
// Self-checking bench for crypto_xif_issuer against a transaction-level model of the id table.
module tb_crypto_xif_issuer;
  import crypto_instr_pkg::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NR_IDS = 4;
  localparam int unsigned TIDB   = 3;
  localparam int unsigned IDW    = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush_i, instr_valid_i, instr_ready_o;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] rs1_i, rs2_i;
  logic [4:0]      rd_i;
  logic [TIDB-1:0] trans_id_i;
  logic            wb_valid_o, wb_we_o, wb_ex_o, busy_o, id_err_o;
  logic [XLEN-1:0] wb_data_o;
  logic [TIDB-1:0] wb_trans_id_o;
  logic [4:0]      wb_rd_o;

  always #5 clk = ~clk;

  crypto_xif_issuer_if #(.XLEN(XLEN), .NR_IDS(NR_IDS)) xif ();

  crypto_xif_issuer #(
    .XLEN(XLEN), .NR_IDS(NR_IDS), .TRANS_ID_BITS(TIDB)
`ifdef CRYPTO_XIF_ISSUE_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .trans_id_i(trans_id_i),
    .xif(xif.master),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_trans_id_o(wb_trans_id_o),
    .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o), .wb_ex_o(wb_ex_o),
    .busy_o(busy_o), .id_err_o(id_err_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: which ids hold an outstanding writeback, and what they return to.
  bit          m_busy   [NR_IDS];
  bit          m_killed [NR_IDS];
  logic [4:0]  m_rd     [NR_IDS];
  logic [2:0]  m_tid    [NR_IDS];
  int unsigned m_ptr;
  bit          m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_any_busy();
    bit b = 1'b0;
    for (int i = 0; i < NR_IDS; i++) b |= m_busy[i];
    return b;
  endfunction

  task automatic m_kill_all();
    for (int i = 0; i < NR_IDS; i++) if (m_busy[i]) m_killed[i] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    flush_i = 1'b0; instr_valid_i = 1'b0; instr_i = '0; rs1_i = '0; rs2_i = '0;
    rd_i = '0; trans_id_i = '0;
    xif.issue_ready = 1'b0; xif.issue_resp = '0;
    xif.result_valid = 1'b0; xif.result_id = '0; xif.result_data = '0;
    for (int i = 0; i < NR_IDS; i++) begin
      m_busy[i] = 1'b0; m_killed[i] = 1'b0; m_rd[i] = '0; m_tid[i] = '0;
    end
    m_ptr = 0; m_err = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
    check("rst_instr_ready", instr_ready_o, 1);
    check("rst_issue_valid", xif.issue_valid, 0);
    check("rst_result_ready", xif.result_ready, 1);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_wb_tid", wb_trans_id_o, 0);
    check("rst_wb_rd", wb_rd_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_id_err", id_err_o, 0);
    check("rst_issue_id", xif.issue_id, 0);
  endtask

  task automatic start_req(input logic [31:0] ins, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [4:0] rd, input logic [2:0] tid);
    check("instr_ready", instr_ready_o, !m_busy[m_ptr]);
    instr_valid_i = 1'b1; instr_i = ins; rs1_i = a; rs2_i = b; rd_i = rd; trans_id_i = tid;
    step();
    instr_valid_i = 1'b0; instr_i = $urandom; rs1_i = $urandom; rs2_i = $urandom;
    check("issue_valid", xif.issue_valid, 1);
    check("issue_instr", xif.issue_instr, ins);
    check("issue_id", xif.issue_id, m_ptr);
    check("issue_rs1", xif.issue_rs1, a);
    check("issue_rs2", xif.issue_rs2, b);
  endtask

  task automatic issue_op(input logic [31:0] ins, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [4:0] rd, input logic [2:0] tid, input issue_resp_t resp,
                          input int unsigned delay);
    bit allocates;
    bit exp_ex;
    allocates = resp.accept && resp.writeback && !resp.register_read[2];
    exp_ex    = !resp.accept || resp.register_read[2];
    start_req(ins, a, b, rd, tid);
    for (int unsigned i = 0; i < delay; i++) begin
      step();
      check("issue_hold_valid", xif.issue_valid, 1);
      check("issue_hold_instr", xif.issue_instr, ins);
    end
    xif.issue_ready = 1'b1; xif.issue_resp = resp;
    step();
    xif.issue_ready = 1'b0; xif.issue_resp = 5'($urandom);
    check("issue_done", xif.issue_valid, 0);
    check("wb_quiet_n1", wb_valid_o, 0);
    if (allocates) begin
      m_busy[m_ptr] = 1'b1; m_killed[m_ptr] = 1'b0; m_rd[m_ptr] = rd; m_tid[m_ptr] = tid;
      m_ptr = (m_ptr + 1) % NR_IDS;
    end else begin
      check("pend_blocks_result", xif.result_ready, 0);
      step();
      check("cpl_wb_valid", wb_valid_o, 1);
      check("cpl_wb_ex", wb_ex_o, exp_ex);
      check("cpl_wb_we", wb_we_o, 0);
      check("cpl_wb_tid", wb_trans_id_o, tid);
      step();
      check("cpl_wb_single", wb_valid_o, 0);
    end
  endtask

  task automatic result_op(input logic [IDW-1:0] id, input logic [XLEN-1:0] data);
    check("result_ready", xif.result_ready, 1);
    xif.result_valid = 1'b1; xif.result_id = id; xif.result_data = data;
    step();
    xif.result_valid = 1'b0; xif.result_id = 2'($urandom); xif.result_data = $urandom;
    if (m_busy[id] && !m_killed[id]) begin
      check("res_wb_valid", wb_valid_o, 1);
      check("res_wb_data", wb_data_o, data);
      check("res_wb_tid", wb_trans_id_o, m_tid[id]);
      check("res_wb_rd", wb_rd_o, m_rd[id]);
      check("res_wb_we", wb_we_o, 1);
      check("res_wb_ex", wb_ex_o, 0);
    end else begin
      check("res_no_wb", wb_valid_o, 0);
      if (!m_busy[id]) m_err = 1'b1;
    end
    m_busy[id] = 1'b0; m_killed[id] = 1'b0;
    check("id_err", id_err_o, m_err);
    check("busy_after_result", busy_o, m_any_busy());
    step();
    check("res_wb_single", wb_valid_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    issue_resp_t r_wb, r_rej, r_rs3, r_nowb, r;
    r_wb   = '{accept: 1'b1, writeback: 1'b1, register_read: 3'b011};
    r_rej  = '{accept: 1'b0, writeback: 1'b1, register_read: 3'b011};
    r_rs3  = '{accept: 1'b1, writeback: 1'b1, register_read: 3'b111};
    r_nowb = '{accept: 1'b1, writeback: 1'b0, register_read: 3'b001};

    reset_dut();

    // accept+writeback, result returns through wb with the captured rd/trans_id
    issue_op(32'h0000_200b, 32'h0000_1111, 32'h0000_2222, 5'd10, 3'd5, r_wb, 1);
    check("busy_outstanding", busy_o, 1);
    result_op(2'd0, 32'hDEADBEEF);

    // rejected, rs3-requiring and non-writeback completions leave alloc_ptr alone
    issue_op(32'h1234_5678, 32'hA, 32'hB, 5'd11, 3'd2, r_rej, 0);
    issue_op(32'h0bad_c0de, 32'hC, 32'hD, 5'd12, 3'd3, r_rs3, 2);
    issue_op(32'h0000_300b, 32'hE, 32'hF, 5'd13, 3'd4, r_nowb, 0);
    issue_op(32'h0000_400b, 32'h5, 32'h6, 5'd14, 3'd6, r_wb, 0);
    result_op(2'd1, 32'h0102_0304);

    // fill the table, free out of order, wrap the allocation pointer
    reset_dut();
    for (int i = 0; i < 4; i++)
      issue_op($urandom, $urandom, $urandom, 5'(i + 1), 3'(i), r_wb, 0);
    check("full_ready", instr_ready_o, 0);
    result_op(2'd2, 32'h2222_0000);
    check("full_after_id2", instr_ready_o, 0);
    result_op(2'd0, 32'h0000_0000);
    check("ready_after_id0", instr_ready_o, 1);
    issue_op(32'h0000_500b, 32'h7, 32'h8, 5'd20, 3'd7, r_wb, 0);
    result_op(2'd1, 32'h1111_1111);
    result_op(2'd3, 32'h3333_3333);
    result_op(2'd0, 32'hFFFF_FFFF);

    // unexpected result id sets a sticky error
    result_op(2'd1, 32'h5555_5555);
    issue_op(32'h0000_600b, 32'h1, 32'h2, 5'd9, 3'd1, r_nowb, 0);
    check("id_err_sticky", id_err_o, 1);

    // flush: kill outstanding work and a request still waiting in REQ
    reset_dut();
    issue_op($urandom, $urandom, $urandom, 5'd1, 3'd1, r_wb, 0);
    issue_op($urandom, $urandom, $urandom, 5'd2, 3'd2, r_wb, 0);
    start_req(32'h0000_700b, 32'h1, 32'h2, 5'd3, 3'd3);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    m_kill_all();
    check("flush_drops_req", xif.issue_valid, 0);
    check("flush_ready", instr_ready_o, 1);
    // flush coincident with an issue handshake: instruction counts as issued, entry killed
    start_req(32'h0000_800b, 32'h3, 32'h4, 5'd4, 3'd4);
    flush_i = 1'b1; xif.issue_ready = 1'b1; xif.issue_resp = r_wb;
    step();
    flush_i = 1'b0; xif.issue_ready = 1'b0;
    m_busy[m_ptr] = 1'b1; m_killed[m_ptr] = 1'b1; m_rd[m_ptr] = 5'd4; m_tid[m_ptr] = 3'd4;
    m_ptr = (m_ptr + 1) % NR_IDS;
    check("flush_hs_issue_valid", xif.issue_valid, 0);
    check("flush_hs_wb", wb_valid_o, 0);
    result_op(2'd1, 32'hAAAA_0001);
    result_op(2'd0, 32'hAAAA_0000);
    result_op(2'd2, 32'hAAAA_0002);
    check("flush_busy_clear", busy_o, 0);
    check("flush_next_id", xif.issue_id, 3);

`ifdef CRYPTO_XIF_ISSUE_TIMEOUT_EN
    // issue_ready held low: the request is abandoned after 8 REQ cycles
    reset_dut();
    start_req(32'h0000_900b, 32'h9, 32'hA, 5'd5, 3'd5);
    for (int i = 0; i < 7; i++) begin
      step();
      check("tmo_waiting", xif.issue_valid, 1);
    end
    step();
    check("tmo_abandon", xif.issue_valid, 0);
    check("tmo_wb_n1", wb_valid_o, 0);
    step();
    check("tmo_wb_valid", wb_valid_o, 1);
    check("tmo_wb_ex", wb_ex_o, 1);
    check("tmo_wb_we", wb_we_o, 0);
    check("tmo_ready", instr_ready_o, 1);
    step();
`endif

    // randomized mix of issues, results and idle flushes
    reset_dut();
    for (int n = 0; n < 300; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 5 && !m_busy[m_ptr]) begin
        int unsigned k;
        k = $urandom_range(0, 9);
        r = 5'($urandom);
        if (k < 6) begin
          r.accept = 1'b1; r.writeback = 1'b1; r.register_read[2] = 1'b0;
        end else if (k < 8) begin
          r.accept = 1'b1; r.writeback = 1'b0; r.register_read[2] = 1'b0;
        end else if ($urandom_range(0, 1) == 0) begin
          r.accept = 1'b0;
        end else begin
          r.accept = 1'b1; r.register_read[2] = 1'b1;
        end
        issue_op($urandom, $urandom, $urandom, 5'($urandom), 3'($urandom), r,
                 $urandom_range(0, 3));
      end else if (sel == 9) begin
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        m_kill_all();
        check("rnd_flush_idle", xif.issue_valid, 0);
        check("rnd_flush_wb", wb_valid_o, 0);
      end else begin
        int unsigned id;
        id = $urandom_range(0, NR_IDS - 1);
        if (m_any_busy() && $urandom_range(0, 7) != 0) begin
          while (!m_busy[id]) id = (id + 1) % NR_IDS;
        end
        result_op(2'(id), $urandom);
      end
      check("rnd_busy", busy_o, m_any_busy());
    end

    reset_dut();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crypto_xif_issuer.md
# crypto_xif_issuer

Core-side initiator for the crypto coprocessor issue/result interface. It takes an offloaded instruction plus operands from the CVA6 issue stage and drives the issue handshake to the coprocessor. It interprets the coprocessor's issue response (accept/writeback/register_read) and tracks outstanding transactions by ID. It then returns results, or illegal-instruction exceptions, to the core writeback port.

## Interface
- XLEN, riscv::XLEN, operand/result width
- NR_IDS, 4, max outstanding writeback transactions (power of 2)
- TRANS_ID_BITS, 3, core scoreboard transaction-id width
- TIMEOUT_CYCLES, 256, issue-handshake timeout (used only with the macro)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  kill pending request and in-flight transactions
- instr_valid_i / instr_ready_o  in/out  1  core-side request handshake
- instr_i  in  32  instruction word; rs1_i, rs2_i  in  XLEN  operands
- rd_i  in  5  destination; trans_id_i  in  TRANS_ID_BITS  scoreboard id
- issue_valid_o / issue_ready_i  out/in  1  coprocessor issue handshake
- issue_instr_o  out  32; issue_id_o  out  $clog2(NR_IDS); issue_rs1_o, issue_rs2_o  out  XLEN
- issue_resp_i  in  issue_resp_t  {accept, writeback, register_read[2:0]}, valid in the issue handshake cycle
- result_valid_i / result_ready_o  in/out  1  result handshake
- result_id_i  in  $clog2(NR_IDS); result_data_i  in  XLEN
- wb_valid_o  out  1; wb_data_o  out  XLEN; wb_trans_id_o  out  TRANS_ID_BITS; wb_rd_o  out  5
- wb_we_o  out  1  register write enable; wb_ex_o  out  1  illegal-instruction exception
- busy_o  out  1  any request or transaction in flight; id_err_o  out  1  sticky unexpected-result-id flag

## Operation
- Request FSM: IDLE, REQ.
  - IDLE: instr_ready_o = !table_full & !pend_q. On handshake, capture instr/operands/rd/trans_id and go to REQ.
  - REQ: issue_valid_o=1; all issue_* outputs stable until issue_ready_i. On handshake, return to IDLE.
- Response decode at issue handshake:
  - accept & writeback & !register_read[2]: allocate entry issue_id_o = alloc_ptr_q {rd, trans_id}; alloc_ptr_q+1, wraps modulo NR_IDS.
  - accept & !writeback: completion with no write; pend_q set with wb_we=0, wb_ex=0.
  - !accept, or register_read[2]=1 (no rs3 path): pend_q set with wb_ex=1, wb_we=0.
- table_full = entry at alloc_ptr_q still busy.
- Results: result_ready_o = !pend_q. On handshake to a busy entry, free it and load the wb register with {data, trans_id, rd, we=1}. A result to a non-busy entry is consumed, produces no wb, and sets id_err_o.
- Writeback register priority: pend_q over result. pend_q clears when loaded into wb.
- flush_i: REQ returns to IDLE without issuing; pend_q cleared; all busy entries marked killed. Killed results are consumed, free their entry and produce no wb. Killed entries block allocation until their result returns.
- id_err_o is cleared only by reset.

## Timing
- Reset: instr_ready_o=1, issue_valid_o=0, result_ready_o=1, wb_valid_o=0, wb_* data 0, busy_o=0, id_err_o=0, alloc_ptr_q=0, table empty.
- Instr handshake at cycle n: issue_valid_o=1 from n+1.
- Result handshake at m: wb_valid_o=1 at m+1, single cycle. There is no wb backpressure.
- Non-writeback or illegal completion, issue handshake at n: pend_q at n+1, wb_valid_o at n+2.
- Throughput: one issue per 2 cycles.
- flush_i has priority over a same-cycle issue handshake; that instruction counts as issued and its entry is killed.

## Configuration
- CRYPTO_XIF_ISSUE_TIMEOUT_EN defined:
  - A counter runs while in REQ.
  - After TIMEOUT_CYCLES cycles without issue_ready_i, abandon the request and set pend_q with wb_ex=1.
  - The counter resets on entering REQ.
- Not defined: REQ waits indefinitely; no counter logic is generated.

## Structure
- crypto_instr_pkg: xif_entry_t {busy, killed, rd, trans_id} and xif_wb_t {data, trans_id, rd, we, ex}.
- Reuse the existing issue_resp_t.
- One sub-module, crypto_xif_id_table: NR_IDS entries with allocate, free, lookup and flush-kill.

## Test plan
- Accept+writeback with a0/a1 and trans_id 5: result id 0, data 0xDEADBEEF at m -> wb_valid at m+1, we=1, trans_id 5, rd matches.
- accept=0 -> wb_ex=1, we=0, wb_valid 2 cycles after the issue handshake; alloc_ptr unchanged.
- Four writeback issues with no results -> instr_ready_o=0. Returning result id 2 leaves it 0, because alloc_ptr=0 is still busy. Returning id 0 restores it; ids wrap 3->0.
- Result for a non-busy id 1 -> no wb, id_err_o=1 and stays set.
- flush_i with 2 outstanding and one request in REQ -> issue_valid_o=0 next cycle; later results consumed with no wb; busy_o=0 after both return.
- Macro defined, TIMEOUT_CYCLES=8, issue_ready_i held 0 -> wb_ex=1 after the timeout; instr_ready_o=1 again.
